flash_ctrl_info_mp_check: RTL and testbench

- Downstream consumer of the per-bank info page config vector produced by the info page privilege stage (after seed/isolation masking).
- Accepts one info-partition operation request at a time and looks up the masked page config. Returns a registered allow/deny response with page attributes (scramble/ECC/high-endurance) to the flash op sequencer.
- Keeps a saturating denial counter for status reporting.

---
 rtl/flash_ctrl_info_mp_check.sv | 171 +++++++++++++++++
 tb/tb_flash_ctrl_info_mp_check.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_ctrl_info_mp_check.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flash_ctrl_info_mp_check
// Brief    : Info-partition memory-protection check with registered response
//            and saturating denial counter.
// Revision : 1.0 - initial release
// ============================================================================
module flash_ctrl_info_mp_check #(
  parameter int INFOS_PER_BANK = 10,
  parameter int NUM_PAGES      = 10,
  parameter int INFO_PAGE_W    = 4,
  parameter int CFG_W          = 7,
  parameter int CNT_W          = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [INFOS_PER_BANK*CFG_W-1:0] cfgs_i,
  input  logic                            req_i,
  output logic                            req_ready_o,
  input  logic [1:0]                      op_i,
  input  logic [INFO_PAGE_W-1:0]          page_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic                            rsp_allow_o,
  output logic [1:0]                      rsp_err_o,
  output logic                            rsp_scramble_en_o,
  output logic                            rsp_ecc_en_o,
  output logic                            rsp_he_en_o,
  output logic [CNT_W-1:0]                deny_cnt_o,
  input  logic                            deny_cnt_clr_i
);

  if (NUM_PAGES > INFOS_PER_BANK) begin : g_bad_num_pages
    $error("NUM_PAGES must not exceed INFOS_PER_BANK");
  end
  if ((2 ** INFO_PAGE_W) < INFOS_PER_BANK) begin : g_bad_page_w
    $error("INFO_PAGE_W too narrow for INFOS_PER_BANK");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e                 r_state;
  logic [1:0]             r_op;
  logic [INFO_PAGE_W-1:0] r_page;
  logic                   r_req_ready;
  logic                   r_rsp_valid;
  logic                   r_allow;
  logic [1:0]             r_err;
  logic                   r_scramble;
  logic                   r_ecc;
  logic                   r_he;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_in_range;
  logic [CFG_W-1:0]       w_cfg;
  logic                   w_perm;
  logic                   w_allow;
  logic [1:0]             w_err;

  // Page select only ever matches in-range pages, so an out-of-bounds index
  // never reaches cfgs_i.
  always_comb begin
    w_in_range = (32'(r_page) < 32'(NUM_PAGES));
    w_cfg      = '0;
    for (int i = 0; i < INFOS_PER_BANK; i++) begin
      if (w_in_range && (32'(r_page) == 32'(i))) begin
        w_cfg = cfgs_i[i*CFG_W +: CFG_W];
      end
    end
  end

  always_comb begin
    w_perm  = 1'b0;
    w_allow = 1'b0;
    w_err   = 2'd0;
    case (r_op)
      2'd0:    w_perm = w_cfg[5];
      2'd1:    w_perm = w_cfg[4];
      2'd2:    w_perm = w_cfg[3];
      default: w_perm = 1'b0;
    endcase
    if (r_op == 2'd3) begin
      w_err = 2'd3;
    end else if (!w_in_range) begin
      w_err = 2'd2;
    end else if (!w_cfg[6] || !w_perm) begin
      w_err = 2'd1;
    end else begin
      w_allow = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_op        <= 2'd0;
      r_page      <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_allow     <= 1'b0;
      r_err       <= 2'd0;
      r_scramble  <= 1'b0;
      r_ecc       <= 1'b0;
      r_he        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            r_op        <= op_i;
            r_page      <= page_i;
            r_req_ready <= 1'b0;
            r_state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_allow     <= w_allow;
          r_err       <= w_err;
          r_scramble  <= w_allow & w_cfg[2];
          r_ecc       <= w_allow & w_cfg[1];
          r_he        <= w_allow & w_cfg[0];
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_allow     <= 1'b0;
            r_err       <= 2'd0;
            r_scramble  <= 1'b0;
            r_ecc       <= 1'b0;
            r_he        <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Clear takes priority over a coincident denial increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (deny_cnt_clr_i) begin
      r_cnt <= '0;
    end else if ((r_state == ST_CHECK) && !w_allow && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign req_ready_o       = r_req_ready;
  assign rsp_valid_o       = r_rsp_valid;
  assign rsp_allow_o       = r_allow;
  assign rsp_err_o         = r_err;
  assign rsp_scramble_en_o = r_scramble;
  assign rsp_ecc_en_o      = r_ecc;
  assign rsp_he_en_o       = r_he;
  assign deny_cnt_o        = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_flash_ctrl_info_mp_check.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_flash_ctrl_info_mp_check
// Brief    : Self-checking bench for flash_ctrl_info_mp_check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_ctrl_info_mp_check;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [69:0] cfgs_i;
  logic        req_i;
  logic        req_ready_o;
  logic [1:0]  op_i;
  logic [3:0]  page_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_allow_o;
  logic [1:0]  rsp_err_o;
  logic        rsp_scramble_en_o;
  logic        rsp_ecc_en_o;
  logic        rsp_he_en_o;
  logic [7:0]  deny_cnt_o;
  logic        deny_cnt_clr_i;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  flash_ctrl_info_mp_check dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .cfgs_i            (cfgs_i),
    .req_i             (req_i),
    .req_ready_o       (req_ready_o),
    .op_i              (op_i),
    .page_i            (page_i),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready_i),
    .rsp_allow_o       (rsp_allow_o),
    .rsp_err_o         (rsp_err_o),
    .rsp_scramble_en_o (rsp_scramble_en_o),
    .rsp_ecc_en_o      (rsp_ecc_en_o),
    .rsp_he_en_o       (rsp_he_en_o),
    .deny_cnt_o        (deny_cnt_o),
    .deny_cnt_clr_i    (deny_cnt_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Expected {allow, err[1:0], scramble, ecc, he} from the access rules.
  function automatic logic [5:0] ref_rsp(input logic [1:0] op, input int page,
                                         input logic [69:0] cfgs);
    logic [6:0] entry;
    if (op == 2'd3) return {1'b0, 2'd3, 3'b000};
    if (page >= 10) return {1'b0, 2'd2, 3'b000};
    entry = 7'((cfgs >> (page * 7)) & 70'h7f);
    if (entry[6] == 1'b0) return {1'b0, 2'd1, 3'b000};
    if (entry[5 - int'(op)] == 1'b0) return {1'b0, 2'd1, 3'b000};
    return {1'b1, 2'd0, entry[2:0]};
  endfunction

  function automatic logic [5:0] payload();
    return {rsp_allow_o, rsp_err_o, rsp_scramble_en_o, rsp_ecc_en_o, rsp_he_en_o};
  endfunction

  function automatic logic [69:0] rand_cfgs();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[69:0];
  endfunction

  function automatic logic [69:0] all_enabled_cfgs();
    logic [69:0] c;
    c = rand_cfgs();
    for (int i = 0; i < 10; i++) c[i*7+3 +: 4] = 4'hf;
    return c;
  endfunction

  // One full transaction with latency, payload and counter checks.
  task automatic run_op(input logic [1:0] op, input logic [3:0] page, input bit clr);
    logic [5:0] exp;
    exp    = ref_rsp(op, int'(page), cfgs_i);
    req_i  = 1'b1;
    op_i   = op;
    page_i = page;
    step();
    req_i = 1'b0;
    deny_cnt_clr_i = clr;
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL check_cycle: valid=%0b ready=%0b required valid=0 ready=0", rsp_valid_o, req_ready_o);
    end
    step();
    deny_cnt_clr_i = 1'b0;
    if (clr) exp_cnt = 0;
    else if (!exp[5] && exp_cnt < 255) exp_cnt++;
    checks++;
    if (rsp_valid_o !== 1'b1 || payload() !== exp) begin
      errors++;
      $display("FAIL rsp op=%0d page=%0d: valid=%0b payload=%b required valid=1 payload=%b",
               op, page, rsp_valid_o, payload(), exp);
    end
    checks++;
    if (deny_cnt_o !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL deny_cnt op=%0d page=%0d: got %0d required %0d", op, page, deny_cnt_o, exp_cnt);
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rsp_release: valid=%0b ready=%0b required valid=0 ready=1", rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || payload() !== 6'd0 || deny_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL reset: ready=%0b valid=%0b payload=%b cnt=%0d required 1 0 000000 0",
               req_ready_o, rsp_valid_o, payload(), deny_cnt_o);
    end
  endtask

  task automatic test_read_allowed();
    cfgs_i = all_enabled_cfgs();
    run_op(2'd0, 4'd3, 1'b0);
  endtask

  task automatic test_mp_denied();
    cfgs_i = all_enabled_cfgs();
    cfgs_i[6:0] = 7'b1100111;
    run_op(2'd1, 4'd0, 1'b0);
    run_op(2'd2, 4'd0, 1'b0);
    run_op(2'd0, 4'd0, 1'b0);
  endtask

  task automatic test_oob_illegal();
    cfgs_i = all_enabled_cfgs();
    run_op(2'($urandom_range(0, 3)), 4'd12, 1'b0);
    run_op(2'd0, 4'd10, 1'b0);
    run_op(2'd3, 4'd2, 1'b0);
    run_op(2'd1, 4'd9, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      cfgs_i = rand_cfgs();
      if ($urandom_range(0, 1) == 1) cfgs_i = cfgs_i | {10{7'b1000000}};
      run_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] held;
    logic [5:0] exp2;
    cfgs_i = all_enabled_cfgs();
    req_i  = 1'b1;
    op_i   = 2'd0;
    page_i = 4'd1;
    step();
    op_i   = 2'd2;
    page_i = 4'd5;
    step();
    held = payload();
    checks++;
    if (rsp_valid_o !== 1'b1 || held !== ref_rsp(2'd0, 1, cfgs_i)) begin
      errors++;
      $display("FAIL bp_first: valid=%0b payload=%b required 1 %b", rsp_valid_o, held, ref_rsp(2'd0, 1, cfgs_i));
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (rsp_valid_o !== 1'b1 || payload() !== held || req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%0b payload=%b ready=%0b required 1 %b 0",
                 k, rsp_valid_o, payload(), req_ready_o, held);
      end
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%0b ready=%0b required 0 1", rsp_valid_o, req_ready_o);
    end
    step();
    req_i = 1'b0;
    checks++;
    if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: ready=%0b valid=%0b required 0 0", req_ready_o, rsp_valid_o);
    end
    step();
    exp2 = ref_rsp(2'd2, 5, cfgs_i);
    checks++;
    if (rsp_valid_o !== 1'b1 || payload() !== exp2) begin
      errors++;
      $display("FAIL bp_second: valid=%0b payload=%b required 1 %b", rsp_valid_o, payload(), exp2);
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_saturation();
    deny_cnt_clr_i = 1'b1;
    step();
    deny_cnt_clr_i = 1'b0;
    exp_cnt = 0;
    for (int n = 0; n < 255; n++) run_op(2'd3, 4'($urandom_range(0, 15)), 1'b0);
    run_op(2'd3, 4'd1, 1'b1);
    for (int n = 0; n < 255; n++) run_op(2'd1, 4'd13, 1'b0);
    run_op(2'd3, 4'd0, 1'b0);
    run_op(2'd1, 4'd11, 1'b0);
  endtask

  task automatic test_async_reset();
    cfgs_i = all_enabled_cfgs();
    req_i  = 1'b1;
    op_i   = 2'd0;
    page_i = 4'd4;
    step();
    req_i  = 1'b0;
    rst_ni = 1'b0;
    exp_cnt = 0;
    step();
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || deny_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b ready=%0b cnt=%0d required 0 1 0",
               rsp_valid_o, req_ready_o, deny_cnt_o);
    end
    rst_ni = 1'b1;
    step();
    run_op(2'd0, 4'd4, 1'b0);
  endtask

  initial begin
    rst_ni         = 1'b0;
    cfgs_i         = '0;
    req_i          = 1'b0;
    op_i           = 2'd0;
    page_i         = '0;
    rsp_ready_i    = 1'b0;
    deny_cnt_clr_i = 1'b0;
    step();
    step();
    test_reset();
    rst_ni = 1'b1;
    step();
    test_reset();
    test_read_allowed();
    test_mp_denied();
    test_oob_illegal();
    test_random();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
